lcd_write_arbiter: RTL and testbench
====================================

Name: lcd_write_arbiter

Overview:
- Shares the single SPI byte-writer engine (9-bit word: bit 8 = DC, bits 7:0 = byte) among up to four word-stream requesters.
- Typical requesters: 0 = init sequencer, 1 = picture/row renderer, 2 = overlay/text.
- Grants whole bursts so that window-address commands and their pixel data are never interleaved.
- Only requester 0 is served until LCD initialisation completes.

Parameters:
- NUM_REQ, 3, number of requesters; legal range 2..4.
- DW, 9, word width {dc, byte}.

Ports:
- sys_clk  in  1  system clock (50 MHz).
- sys_rst  in  1  synchronous reset, active-high.
- init_done  in  1  high once LCD init is complete; gates requesters 1..NUM_REQ-1.
- req_valid  in  NUM_REQ  per-requester word valid. Held with data until the matching req_ready.
- req_last  in  NUM_REQ  qualifies req_valid: this word ends the burst.
- req_data  in  NUM_REQ*DW  flattened words; requester i occupies bits [i*DW +: DW].
- req_ready  out  NUM_REQ  one-cycle pulse: word accepted.
- wr_data  out  DW  word to the writer engine.
- wr_en  out  1  one-cycle start pulse to the engine.
- wr_done  in  1  engine one-cycle done pulse.
- grant_id  out  2  index of the requester currently owning the engine.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (sync, sys_rst=1): state=IDLE; wr_en=0, wr_data=0, req_ready=0, grant_id=0, busy=0, last_q=0, RR pointer=0. Reset mid-burst abandons the burst; no wr_en is issued afterwards until a new grant.
- Eligibility: eligible[i] = req_valid[i] && (i==0 || init_done).
- States:
  - IDLE: if any requester is eligible, pick winner g by priority. Register grant_id=g, wr_data=req_data[g], last_q=req_last[g], then go to ISSUE.
  - ISSUE (exactly 1 cycle): wr_en=1, req_ready[g]=1. Next state is WAIT.
  - WAIT: hold wr_data. On wr_done, go to IDLE if last_q, else go to HOLD.
  - HOLD: burst lock. Only req_valid[grant_id] is examined; init_done is not re-checked. When valid, latch data and last, then go to ISSUE. Other requesters stall indefinitely while HOLD is active.
- Priority (default): fixed, lowest index wins.
- Latency:
  - Eligible request seen in IDLE at cycle t → wr_en and req_ready at t+1.
  - wr_done at cycle t, next word already valid → HOLD at t+1, wr_en at t+2.
- req_ready and wr_en are always asserted in the same cycle; never more than one req_ready bit is high.
- wr_done outside WAIT is ignored; no state change.
- req_valid deasserted by a non-granted requester has no effect.
- grant_id holds its last value in IDLE.
- Single-word burst (req_last=1 on the first word): IDLE→ISSUE→WAIT→IDLE.
- init_done falling mid-burst: the current burst completes. Subsequent arbitration re-applies gating.
- Simultaneous eligible requests in IDLE: exactly one grant, per priority; the others keep valid asserted.

Optional Feature:
- Macro: LCD_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - Search starts at pointer rr_ptr.
  - On leaving WAIT for IDLE (burst end), rr_ptr = (grant_id+1) mod NUM_REQ.
  - Init gating still applies.
- Undefined: fixed priority as above; no pointer register is synthesised.

Test Plan:
- Reset, then init_done=0, req_valid=3'b110 → no wr_en for 50 cycles; busy=0; req_ready=0.
- init_done=0, requester 0 sends 3-word burst 0x011,0x1A0,0x1FF (last on the 3rd); engine answers wr_done 20 cycles after each wr_en → wr_data sequence matches; exactly 3 req_ready[0] pulses; busy drops 1 cycle after the 3rd wr_done.
- init_done=1; req 1 and req 2 both valid in the same cycle, each a 2-word burst → fixed priority: all of req 1's words are issued before any of req 2's; grant_id=1 then 2.
- Lock: req 1 mid-burst drops valid for 30 cycles while req 2 is valid → no req 2 grant during the gap; req 1 resumes and completes, then req 2 is granted.
- wr_done pulses injected in IDLE and HOLD → no state change, no wr_en.
- Reset asserted during WAIT → next cycle wr_en=0, busy=0, grant_id=0. With LCD_ARB_ROUND_ROBIN_EN: req 0, 1 and 2 continuously valid with single-word bursts → grant order 0,1,2,0,1,2.

Source files
------------

// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter
// Shares one SPI byte-writer engine (9-bit words: {dc, byte}) between up to
// four word-stream requesters. A grant covers a whole burst (up to and
// including the word flagged with req_last), so a window-address command
// and the pixel data that follows it can never be interleaved with another
// stream. Requesters other than 0 are gated off until init_done is high.
//
// Build option: define LCD_ARB_ROUND_ROBIN_EN for round-robin arbitration
// between bursts. Without it, arbitration is fixed priority (lowest index
// wins) and no pointer register exists.

module lcd_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DW      = 9
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  init_done,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_last,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [DW-1:0]         wr_data,
    output logic                  wr_en,
    input  logic                  wr_done,
    output logic [1:0]            grant_id,
    output logic                  busy
);

    // Internal vectors are padded to the maximum requester count so that a
    // 2-bit index can address them without running off the end.
    localparam int MAX_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t                 state_r;
    logic                   last_q_r;
    logic                   wr_en_r;
    logic [DW-1:0]          wr_data_r;
    logic [NUM_REQ-1:0]     req_ready_r;
    logic [1:0]             grant_id_r;
    logic                   busy_r;

    logic [MAX_REQ-1:0]     valid_pad_s;
    logic [MAX_REQ-1:0]     last_pad_s;
    logic [MAX_REQ*DW-1:0]  data_pad_s;
    logic [MAX_REQ-1:0]     eligible_s;
    logic                   any_eligible_s;
    logic [1:0]             winner_s;

    // Next index in the ring of implemented requesters.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        logic [1:0] nxt;
        if (idx == 2'(NUM_REQ - 1)) begin
            nxt = 2'd0;
        end else begin
            nxt = idx + 2'd1;
        end
        return nxt;
    endfunction

    // One-hot ready pattern for a given requester index.
    function automatic logic [NUM_REQ-1:0] onehot_ready(input logic [1:0] idx);
        logic [MAX_REQ-1:0] vec;
        vec = 4'b0001 << idx;
        return vec[NUM_REQ-1:0];
    endfunction

    // Word mux out of the padded data bus.
    function automatic logic [DW-1:0] pick_word(input logic [MAX_REQ*DW-1:0] bus,
                                                input logic [1:0]            idx);
        logic [DW-1:0] word;
        case (idx)
            2'd0:    word = bus[0*DW +: DW];
            2'd1:    word = bus[1*DW +: DW];
            2'd2:    word = bus[2*DW +: DW];
            2'd3:    word = bus[3*DW +: DW];
            default: word = '0;
        endcase
        return word;
    endfunction

    // Pad request inputs to four lanes; absent lanes read as idle.
    always_comb begin
        valid_pad_s = '0;
        last_pad_s  = '0;
        data_pad_s  = '0;
        valid_pad_s[NUM_REQ-1:0]    = req_valid;
        last_pad_s[NUM_REQ-1:0]     = req_last;
        data_pad_s[NUM_REQ*DW-1:0]  = req_data;
    end

    // Requester 0 (init sequencer) is always eligible; others wait for init_done.
    always_comb begin
        eligible_s    = '0;
        eligible_s[0] = valid_pad_s[0];
        for (int i = 1; i < MAX_REQ; i++) begin
            eligible_s[i] = valid_pad_s[i] & init_done;
        end
        any_eligible_s = |eligible_s;
    end

`ifdef LCD_ARB_ROUND_ROBIN_EN
    logic [1:0] rr_ptr_r;

    // Round-robin pick: first eligible requester at or after rr_ptr_r.
    always_comb begin : rr_pick
        logic [1:0] idx;
        logic       found;
        winner_s = 2'd0;
        idx      = rr_ptr_r;
        found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            winner_s = (!found && eligible_s[idx]) ? idx : winner_s;
            found    = found | eligible_s[idx];
            idx      = next_idx(idx);
        end
    end

    // Advance the pointer past the requester whose burst just ended.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rr_ptr_r <= 2'd0;
        end else if (state_r == ST_WAIT && wr_done && last_q_r) begin
            rr_ptr_r <= next_idx(grant_id_r);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`else
    // Fixed priority pick: lowest eligible index wins.
    always_comb begin
        winner_s = 2'd0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            winner_s = eligible_s[i] ? 2'(i) : winner_s;
        end
    end
`endif

    // Burst FSM; wr_en/req_ready are loaded on entry to ISSUE so that they are
    // high for exactly the single ISSUE cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r     <= ST_IDLE;
            wr_en_r     <= 1'b0;
            wr_data_r   <= '0;
            req_ready_r <= '0;
            grant_id_r  <= 2'd0;
            busy_r      <= 1'b0;
            last_q_r    <= 1'b0;
        end else begin
            wr_en_r     <= 1'b0;
            req_ready_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (any_eligible_s) begin
                        grant_id_r  <= winner_s;
                        wr_data_r   <= pick_word(data_pad_s, winner_s);
                        last_q_r    <= last_pad_s[winner_s];
                        wr_en_r     <= 1'b1;
                        req_ready_r <= onehot_ready(winner_s);
                        busy_r      <= 1'b1;
                        state_r     <= ST_ISSUE;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wr_done) begin
                        if (last_q_r) begin
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_HOLD;
                        end
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    // Burst lock: only the owner is looked at, init gating is
                    // deliberately not re-applied mid-burst.
                    if (valid_pad_s[grant_id_r]) begin
                        wr_data_r   <= pick_word(data_pad_s, grant_id_r);
                        last_q_r    <= last_pad_s[grant_id_r];
                        wr_en_r     <= 1'b1;
                        req_ready_r <= onehot_ready(grant_id_r);
                        state_r     <= ST_ISSUE;
                    end else begin
                        state_r     <= ST_HOLD;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_en     = wr_en_r;
    assign wr_data   = wr_data_r;
    assign req_ready = req_ready_r;
    assign grant_id  = grant_id_r;
    assign busy      = busy_r;

    lcd_write_arbiter_chk #(
        .NUM_REQ (NUM_REQ)
    ) u_chk (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req_ready (req_ready_r),
        .wr_en     (wr_en_r),
        .busy      (busy_r)
    );

endmodule

// Handshake invariants of the arbiter outputs.
module lcd_write_arbiter_chk #(
    parameter int NUM_REQ = 3
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [NUM_REQ-1:0] req_ready,
    input  logic               wr_en,
    input  logic               busy
);

    // At most one ready, ready always coincides with wr_en, wr_en implies busy.
    always @(posedge sys_clk) begin
        if (!sys_rst) begin
            a_ready_onehot: assert ($onehot0(req_ready));
            a_ready_wr_en:  assert ((|req_ready) == wr_en);
            a_wr_en_busy:   assert (!wr_en || busy);
        end
    end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter: gating before init, burst sequencing,
// fixed priority, burst lock, stray wr_done pulses, reset mid-burst and the
// between-burst arbitration order (fixed or round-robin).

module tb_lcd_write_arbiter;

    localparam int NUM_REQ = 3;
    localparam int DW      = 9;

    logic                  sys_clk;
    logic                  sys_rst;
    logic                  init_done;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_last;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [DW-1:0]         wr_data;
    logic                  wr_en;
    logic                  wr_done;
    logic [1:0]            grant_id;
    logic                  busy;

    int vectors;
    int miscompares;
    int ready0_cnt;
    int wr_en_cnt;
    int hs_bad_cnt;

    lcd_write_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DW      (DW)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .init_done (init_done),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .wr_done   (wr_done),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    // 50 MHz clock
    initial begin
        sys_clk = 1'b0;
        forever #10 sys_clk = ~sys_clk;
    end

    // Mid-cycle observers: pulse counters and handshake consistency.
    always @(negedge sys_clk) begin
        if (req_ready[0] === 1'b1) ready0_cnt++;
        if (wr_en === 1'b1) wr_en_cnt++;
        if (((|req_ready) !== wr_en) || !$onehot0(req_ready)) hs_bad_cnt++;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic l, input logic [DW-1:0] d);
        req_valid[i]       = v;
        req_last[i]        = l;
        req_data[i*DW +: DW] = d;
    endtask

    // Wait (bounded) for the next wr_en and check the issued word.
    task automatic issue(input string tag, input logic [DW-1:0] exp_data, input logic [1:0] exp_gid);
        int lat;
        logic [NUM_REQ-1:0] exp_rdy;
        exp_rdy = 3'b001 << exp_gid;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (wr_en !== 1'b1 && lat < 200);
        chk({tag, "/latency"},   32'(lat),       32'd1);
        chk({tag, "/wr_data"},   32'(wr_data),   32'(exp_data));
        chk({tag, "/grant_id"},  32'(grant_id),  32'(exp_gid));
        chk({tag, "/req_ready"}, 32'(req_ready), 32'(exp_rdy));
    endtask

    // Engine model: done pulse after gap cycles, then step into the next cycle.
    task automatic engine_done(input int gap);
        repeat (gap) tick();
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
    endtask

    initial begin
        int e0;
        int r0;
        int bad;
        vectors     = 0;
        miscompares = 0;
        ready0_cnt  = 0;
        wr_en_cnt   = 0;
        hs_bad_cnt  = 0;
        sys_rst     = 1'b1;
        init_done   = 1'b0;
        req_valid   = '0;
        req_last    = '0;
        req_data    = '0;
        wr_done     = 1'b0;

        // Reset state
        repeat (3) tick();
        sys_rst = 1'b0;
        chk("rst/wr_en",     32'(wr_en),     32'd0);
        chk("rst/busy",      32'(busy),      32'd0);
        chk("rst/grant_id",  32'(grant_id),  32'd0);
        chk("rst/req_ready", 32'(req_ready), 32'd0);
        chk("rst/wr_data",   32'(wr_data),   32'd0);

        // Requesters 1 and 2 gated while init_done is low
        set_req(1, 1'b1, 1'b0, 9'h120);
        set_req(2, 1'b1, 1'b0, 9'h150);
        e0  = wr_en_cnt;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (busy !== 1'b0 || req_ready !== 3'b000) bad++;
        end
        chk("gate/wr_en_count", 32'(wr_en_cnt - e0), 32'd0);
        chk("gate/busy_ready",  32'(bad),            32'd0);

        // Requester 0 three-word burst before init completes
        r0 = ready0_cnt;
        set_req(0, 1'b1, 1'b0, 9'h011);
        issue("init_w0", 9'h011, 2'd0);
        set_req(0, 1'b1, 1'b0, 9'h1A0);
        engine_done(20);
        chk("init_w0/hold_busy",  32'(busy),  32'd1);
        chk("init_w0/hold_wr_en", 32'(wr_en), 32'd0);
        issue("init_w1", 9'h1A0, 2'd0);
        set_req(0, 1'b1, 1'b1, 9'h1FF);
        engine_done(20);
        chk("init_w1/hold_busy",  32'(busy),  32'd1);
        issue("init_w2", 9'h1FF, 2'd0);
        set_req(0, 1'b0, 1'b0, 9'h000);
        engine_done(20);
        chk("init_end/busy",     32'(busy),              32'd0);
        chk("init_end/ready0",   32'(ready0_cnt - r0),   32'd3);
        e0 = wr_en_cnt;
        repeat (5) tick();
        chk("init_end/no_grant", 32'(wr_en_cnt - e0),    32'd0);

        // init_done rises with requesters 1 and 2 both pending
        init_done = 1'b1;
        issue("prio_r1w0", 9'h120, 2'd1);
        set_req(1, 1'b1, 1'b1, 9'h121);
        engine_done(20);
        issue("prio_r1w1", 9'h121, 2'd1);
        set_req(1, 1'b0, 1'b0, 9'h000);
        engine_done(20);
        chk("prio_r1end/busy",     32'(busy),     32'd0);
        chk("prio_r1end/grant_id", 32'(grant_id), 32'd1);
        issue("prio_r2w0", 9'h150, 2'd2);
        set_req(2, 1'b1, 1'b1, 9'h151);
        engine_done(20);
        issue("prio_r2w1", 9'h151, 2'd2);
        set_req(2, 1'b0, 1'b0, 9'h000);
        engine_done(20);
        chk("prio_r2end/busy", 32'(busy), 32'd0);

        // Burst lock: requester 1 stalls mid-burst, requester 2 must wait
        set_req(1, 1'b1, 1'b0, 9'h130);
        set_req(2, 1'b1, 1'b1, 9'h160);
        issue("lock_r1w0", 9'h130, 2'd1);
        set_req(1, 1'b0, 1'b0, 9'h000);
        engine_done(20);
        e0  = wr_en_cnt;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            wr_done = (i == 10 || i == 20) ? 1'b1 : 1'b0;
            tick();
            if (busy !== 1'b1) bad++;
        end
        wr_done = 1'b0;
        chk("lock/wr_en_count", 32'(wr_en_cnt - e0), 32'd0);
        chk("lock/busy_held",   32'(bad),            32'd0);
        chk("lock/grant_id",    32'(grant_id),       32'd1);
        set_req(1, 1'b1, 1'b1, 9'h131);
        issue("lock_r1w1", 9'h131, 2'd1);
        set_req(1, 1'b0, 1'b0, 9'h000);
        engine_done(20);
        issue("lock_r2w0", 9'h160, 2'd2);
        set_req(2, 1'b0, 1'b0, 9'h000);
        engine_done(20);
        chk("lock_end/busy", 32'(busy), 32'd0);

        // Stray wr_done in IDLE
        e0 = wr_en_cnt;
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        repeat (5) tick();
        chk("idle_done/wr_en_count", 32'(wr_en_cnt - e0), 32'd0);
        chk("idle_done/busy",        32'(busy),           32'd0);
        chk("idle_done/grant_id",    32'(grant_id),       32'd2);

        // init_done falls mid-burst: burst finishes, then gating returns
        set_req(1, 1'b1, 1'b0, 9'h140);
        issue("initfall_w0", 9'h140, 2'd1);
        set_req(1, 1'b1, 1'b1, 9'h141);
        init_done = 1'b0;
        engine_done(20);
        issue("initfall_w1", 9'h141, 2'd1);
        set_req(1, 1'b1, 1'b1, 9'h142);
        engine_done(20);
        e0 = wr_en_cnt;
        repeat (10) tick();
        chk("initfall/wr_en_count", 32'(wr_en_cnt - e0), 32'd0);
        chk("initfall/busy",        32'(busy),           32'd0);
        set_req(1, 1'b0, 1'b0, 9'h000);

        // Reset while waiting for the engine
        init_done = 1'b1;
        set_req(1, 1'b1, 1'b1, 9'h0AA);
        issue("rstwait", 9'h0AA, 2'd1);
        set_req(1, 1'b0, 1'b0, 9'h000);
        repeat (3) tick();
        sys_rst = 1'b1;
        tick();
        chk("rstwait/wr_en",    32'(wr_en),    32'd0);
        chk("rstwait/busy",     32'(busy),     32'd0);
        chk("rstwait/grant_id", 32'(grant_id), 32'd0);
        chk("rstwait/wr_data",  32'(wr_data),  32'd0);
        sys_rst = 1'b0;
        e0 = wr_en_cnt;
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        repeat (10) tick();
        chk("rstwait/no_reissue", 32'(wr_en_cnt - e0), 32'd0);

        // Arbitration order with all three continuously requesting single words
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, 1'b1, 1'b1, 9'(9'h100 + i));
        end
        for (int n = 0; n < 6; n++) begin
            logic [1:0] g;
`ifdef LCD_ARB_ROUND_ROBIN_EN
            g = 2'(n % NUM_REQ);
`else
            g = 2'd0;
`endif
            issue($sformatf("order%0d", n), 9'(9'h100 + g), g);
            engine_done(3);
        end
        req_valid = '0;
        repeat (30) tick();
        chk("order_end/busy", 32'(busy), 32'd0);

        chk("handshake_consistency", 32'(hs_bad_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
